// File: rtl/sr_flop_bank.sv
// rtl/sr_flop_bank.sv - clocked bank of SR flops with deterministic S=R=1 resolution and conflict tracking
module sr_flop_bank #(
    parameter int CHANNELS = 8,
    parameter int MODE     = 1,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [CHANNELS-1:0] S,
    input  logic [CHANNELS-1:0] R,
    input  logic                clr_conflict,
    output logic [CHANNELS-1:0] Q,
    output logic [CHANNELS-1:0] Qbar,
    output logic [CHANNELS-1:0] chg,
    output logic [CHANNELS-1:0] conflict,
    output logic [CNT_W-1:0]    conflict_cnt
);

    if (CHANNELS < 1 || CHANNELS > 32 || MODE < 0 || MODE > 3 || CNT_W < 2 || CNT_W > 16) begin : g_bad_param
        $error("sr_flop_bank: illegal parameter value");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CHANNELS-1:0] both_val;
    logic [CHANNELS-1:0] q_next;
    logic [CHANNELS-1:0] hits;
    logic                any_hit;

    // Value taken by a channel when S and R are both asserted.
    always_comb begin
        case (MODE)
            0:       both_val = Q;
            1:       both_val = '1;
            2:       both_val = '0;
            default: both_val = ~Q;
        endcase
        q_next  = (Q & ~S & ~R) | (S & ~R) | (S & R & both_val);
        hits    = en ? (S & R) : '0;
        any_hit = |hits;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Q            <= '0;
            chg          <= '0;
            conflict     <= '0;
            conflict_cnt <= '0;
        end else begin
            if (en) begin
                Q   <= q_next;
                chg <= q_next ^ Q;
            end else begin
                chg <= '0;
            end
            // A conflict sampled on the clearing edge survives the clear.
            if (clr_conflict) begin
                conflict     <= hits;
                conflict_cnt <= any_hit ? CNT_W'(1) : '0;
            end else if (any_hit) begin
                conflict <= conflict | hits;
                if (conflict_cnt != CNT_MAX) begin
                    conflict_cnt <= conflict_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign Qbar = ~Q;

endmodule

// File: tb/tb_sr_flop_bank.sv
// tb/tb_sr_flop_bank.sv - directed bench for sr_flop_bank, one 4-channel instance per MODE
module tb_sr_flop_bank;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] s;
    logic [3:0] r;
    logic       clr;
    logic [3:0] q   [4];
    logic [3:0] qb  [4];
    logic [3:0] chg [4];
    logic [3:0] cf  [4];
    logic [1:0] cnt [4];

    int total;
    int passed;

    logic [3:0] exp_q   [4];
    logic [3:0] exp_chg [4];

    for (genvar m = 0; m < 4; m++) begin : g_dut
        sr_flop_bank #(.CHANNELS(4), .MODE(m), .CNT_W(2)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .en           (en),
            .S            (s),
            .R            (r),
            .clr_conflict (clr),
            .Q            (q[m]),
            .Qbar         (qb[m]),
            .chg          (chg[m]),
            .conflict     (cf[m]),
            .conflict_cnt (cnt[m])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; s = '0; r = '0; clr = 1'b0;
        tick();
        tick();
        for (int m = 0; m < 4; m++) begin
            total++;
            if (q[m] !== 4'b0000 || qb[m] !== 4'b1111 || chg[m] !== 4'b0000 || cf[m] !== 4'b0000 || cnt[m] !== 2'd0)
                $display("FAIL reset mode%0d: Q=%b Qbar=%b chg=%b conflict=%b cnt=%0d, required 0000 1111 0000 0000 0", m, q[m], qb[m], chg[m], cf[m], cnt[m]);
            else passed++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        s = 4'b0101; r = 4'b0000;
        tick();
        for (int m = 0; m < 4; m++) begin
            total++;
            if (q[m] !== 4'b0101 || qb[m] !== 4'b1010 || chg[m] !== 4'b0101)
                $display("FAIL basic_set mode%0d: Q=%b Qbar=%b chg=%b, required 0101 1010 0101", m, q[m], qb[m], chg[m]);
            else passed++;
        end
        s = '0;
        tick();
        for (int m = 0; m < 4; m++) begin
            total++;
            if (q[m] !== 4'b0101 || chg[m] !== 4'b0000)
                $display("FAIL basic_hold mode%0d: Q=%b chg=%b, required 0101 0000", m, q[m], chg[m]);
            else passed++;
        end
    endtask

    task automatic test_conflict_resolution();
        s = 4'b0011; r = 4'b1100;
        tick();
        for (int m = 0; m < 4; m++) begin
            total++;
            if (q[m] !== 4'b0011 || chg[m] !== 4'b0110 || cf[m] !== 4'b0000)
                $display("FAIL preset mode%0d: Q=%b chg=%b conflict=%b, required 0011 0110 0000", m, q[m], chg[m], cf[m]);
            else passed++;
        end
        exp_q[0] = 4'b0011; exp_q[1] = 4'b1111; exp_q[2] = 4'b0000; exp_q[3] = 4'b1100;
        exp_chg[0] = 4'b0000; exp_chg[1] = 4'b1100; exp_chg[2] = 4'b0011; exp_chg[3] = 4'b1111;
        s = 4'b1111; r = 4'b1111;
        tick();
        for (int m = 0; m < 4; m++) begin
            total++;
            if (q[m] !== exp_q[m] || qb[m] !== ~exp_q[m] || chg[m] !== exp_chg[m] || cf[m] !== 4'b1111 || cnt[m] !== 2'd1)
                $display("FAIL conflict mode%0d: Q=%b chg=%b conflict=%b cnt=%0d, required %b %b 1111 1", m, q[m], chg[m], cf[m], cnt[m], exp_q[m], exp_chg[m]);
            else passed++;
        end
        s = '0; r = '0;
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [5];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int m = 0; m < 4; m++) begin
            total++;
            if (cf[m] !== 4'b0000 || cnt[m] !== 2'd0)
                $display("FAIL clear mode%0d: conflict=%b cnt=%0d, required 0000 0", m, cf[m], cnt[m]);
            else passed++;
        end
        s = 4'b0001; r = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            tick();
            for (int m = 0; m < 4; m++) begin
                total++;
                if (cnt[m] !== exp_cnt[k] || cf[m] !== 4'b0001)
                    $display("FAIL saturate%0d mode%0d: cnt=%0d conflict=%b, required %0d 0001", k, m, cnt[m], cf[m], exp_cnt[k]);
                else passed++;
            end
        end
        s = '0; r = '0;
    endtask

    task automatic test_clear_vs_conflict();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        s = 4'b0011; r = 4'b0011;
        tick();
        tick();
        for (int m = 0; m < 4; m++) begin
            total++;
            if (cf[m] !== 4'b0011 || cnt[m] !== 2'd2)
                $display("FAIL clr_setup mode%0d: conflict=%b cnt=%0d, required 0011 2", m, cf[m], cnt[m]);
            else passed++;
        end
        clr = 1'b1; s = 4'b0100; r = 4'b0100;
        tick();
        for (int m = 0; m < 4; m++) begin
            total++;
            if (cf[m] !== 4'b0100 || cnt[m] !== 2'd1)
                $display("FAIL clr_with_conflict mode%0d: conflict=%b cnt=%0d, required 0100 1", m, cf[m], cnt[m]);
            else passed++;
        end
        s = '0; r = '0;
        tick();
        for (int m = 0; m < 4; m++) begin
            total++;
            if (cf[m] !== 4'b0000 || cnt[m] !== 2'd0)
                $display("FAIL clr_only mode%0d: conflict=%b cnt=%0d, required 0000 0", m, cf[m], cnt[m]);
            else passed++;
        end
        clr = 1'b0;
    endtask

    task automatic test_enable();
        s = 4'b1010; r = 4'b0101;
        tick();
        s = 4'b0001; r = 4'b0001;
        tick();
        s = 4'b1010; r = 4'b0101;
        tick();
        en = 1'b0; s = 4'b1111; r = 4'b1111;
        tick();
        tick();
        for (int m = 0; m < 4; m++) begin
            total++;
            if (q[m] !== 4'b1010 || chg[m] !== 4'b0000 || cf[m] !== 4'b0001 || cnt[m] !== 2'd1)
                $display("FAIL en_low mode%0d: Q=%b chg=%b conflict=%b cnt=%0d, required 1010 0000 0001 1", m, q[m], chg[m], cf[m], cnt[m]);
            else passed++;
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int m = 0; m < 4; m++) begin
            total++;
            if (q[m] !== 4'b1010 || cf[m] !== 4'b0000 || cnt[m] !== 2'd0)
                $display("FAIL en_low_clr mode%0d: Q=%b conflict=%b cnt=%0d, required 1010 0000 0", m, q[m], cf[m], cnt[m]);
            else passed++;
        end
        en = 1'b1; s = 4'b0101; r = 4'b1010;
        tick();
        for (int m = 0; m < 4; m++) begin
            total++;
            if (q[m] !== 4'b0101 || chg[m] !== 4'b1111 || cf[m] !== 4'b0000)
                $display("FAIL en_resume mode%0d: Q=%b chg=%b conflict=%b, required 0101 1111 0000", m, q[m], chg[m], cf[m]);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        s = 4'b1111; r = 4'b1111;
        tick();
        tick();
        tick();
        s = 4'b1010; r = 4'b0101;
        tick();
        for (int m = 0; m < 4; m++) begin
            total++;
            if (q[m] !== 4'b1010 || cnt[m] !== 2'd3)
                $display("FAIL pre_reset mode%0d: Q=%b cnt=%0d, required 1010 3", m, q[m], cnt[m]);
            else passed++;
        end
        #3;
        rst_n = 1'b0;
        #1;
        for (int m = 0; m < 4; m++) begin
            total++;
            if (q[m] !== 4'b0000 || qb[m] !== 4'b1111 || chg[m] !== 4'b0000 || cf[m] !== 4'b0000 || cnt[m] !== 2'd0)
                $display("FAIL async_reset mode%0d: Q=%b Qbar=%b chg=%b conflict=%b cnt=%0d, required 0000 1111 0000 0000 0", m, q[m], qb[m], chg[m], cf[m], cnt[m]);
            else passed++;
        end
        tick();
        for (int m = 0; m < 4; m++) begin
            total++;
            if (q[m] !== 4'b0000 || cf[m] !== 4'b0000 || cnt[m] !== 2'd0)
                $display("FAIL reset_hold mode%0d: Q=%b conflict=%b cnt=%0d, required 0000 0000 0", m, q[m], cf[m], cnt[m]);
            else passed++;
        end
        rst_n = 1'b1; s = '0; r = '0;
        tick();
        for (int m = 0; m < 4; m++) begin
            total++;
            if (q[m] !== 4'b0000 || chg[m] !== 4'b0000)
                $display("FAIL post_reset mode%0d: Q=%b chg=%b, required 0000 0000", m, q[m], chg[m]);
            else passed++;
        end
    endtask

    initial begin
        total  = 0;
        passed = 0;
        test_reset();
        test_basic();
        test_conflict_resolution();
        test_saturation();
        test_clear_vs_conflict();
        test_enable();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
